// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_ctrl_if #(
  parameter int ALUOP_W = 2
);
  logic [5:0]         op;
  logic               mem_ready;
  logic               pcwrite;
  logic               branch;
  logic               branch_ne;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic               zeroext;
  logic [1:0]         pcsrc;
  logic [ALUOP_W-1:0] alu_op;
  logic               instr_done;
  logic               illegal_op;
  logic [3:0]         state;

  modport master (
    input  op, mem_ready,
    output pcwrite, branch, branch_ne, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, zeroext, pcsrc, alu_op, instr_done,
           illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, branch_ne, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, zeroext, pcsrc, alu_op, instr_done,
           illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: registered Moore FSM sequencing one
// instruction over 3-5 cycles (plus memory wait states).
//
// state   | meaning
// --------+--------------------------------------------------
// FETCH   | read instruction at PC, PC += 4 when memory ready
// DECODE  | read registers, precompute branch target
// MEMADR  | compute load/store address rs + imm
// MEMRD   | load data read from ALUOut address
// MEMWB   | write MDR to rt
// MEMWR   | store rt to ALUOut address
// RTYPEEX | ALU op on rs, rt using funct
// ALUWB   | write ALUOut to rd
// ADDIEX  | rs + sign-extended imm
// ORIEX   | rs | zero-extended imm
// IMMWB   | write ALUOut to rt
// BEQEX   | compare rs - rt, load PC if equal
// BNEEX   | compare rs - rt, load PC if not equal
// JEX     | load PC with jump target
module mips_multicycle_ctrl #(
  parameter int ALUOP_W  = 2,
  parameter int EN_EXT   = 1,
  parameter int MEM_WAIT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  mips_multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    ADDIEX  = 4'd8,
    ORIEX   = 4'd9,
    IMMWB   = 4'd10,
    BEQEX   = 4'd11,
    BNEEX   = 4'd12,
    JEX     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t r_state;
  state_t w_state_nxt;

  logic               w_rdy;
  logic               w_pcwrite;
  logic               w_branch;
  logic               w_branch_ne;
  logic               w_memwrite;
  logic               w_irwrite;
  logic               w_regwrite;
  logic               w_iord;
  logic               w_regdst;
  logic               w_memtoreg;
  logic               w_alusrca;
  logic [1:0]         w_alusrcb;
  logic               w_zeroext;
  logic [1:0]         w_pcsrc;
  logic [ALUOP_W-1:0] w_alu_op;
  logic               w_instr_done;
  logic               w_illegal_op;

  // Without wait-state support memory is assumed to complete every access.
  assign w_rdy = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

  // State register; async reset returns to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= FETCH;
    else          r_state <= w_state_nxt;
  end

  // Next-state and Moore output decode (mem_ready only matters in memory states).
  always_comb begin
    w_state_nxt  = FETCH;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_branch_ne  = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_iord       = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 2'b00;
    w_zeroext    = 1'b0;
    w_pcsrc      = 2'b00;
    w_alu_op     = '0;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;
    case (r_state)
      FETCH: begin
        w_alusrcb   = 2'b01;
        w_irwrite   = w_rdy;
        w_pcwrite   = w_rdy;
        w_state_nxt = w_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_RTYPE:      w_state_nxt = RTYPEEX;
          OP_LW, OP_SW:  w_state_nxt = MEMADR;
          OP_BEQ:        w_state_nxt = BEQEX;
          OP_ADDI:       w_state_nxt = ADDIEX;
          OP_J:          w_state_nxt = JEX;
          OP_ORI: begin
            if (EN_EXT != 0) w_state_nxt = ORIEX;
            else begin
              w_illegal_op = 1'b1;
              w_instr_done = 1'b1;
            end
          end
          OP_BNE: begin
            if (EN_EXT != 0) w_state_nxt = BNEEX;
            else begin
              w_illegal_op = 1'b1;
              w_instr_done = 1'b1;
            end
          end
          default: begin
            w_illegal_op = 1'b1;
            w_instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_state_nxt = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_iord      = 1'b1;
        w_state_nxt = w_rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        w_memtoreg   = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      MEMWR: begin
        w_iord       = 1'b1;
        w_memwrite   = 1'b1;
        w_instr_done = w_rdy;
        w_state_nxt  = w_rdy ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        w_alusrca     = 1'b1;
        w_alu_op[1:0] = 2'b10;
        w_state_nxt   = ALUWB;
      end
      ALUWB: begin
        w_regdst     = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      ADDIEX: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_state_nxt = IMMWB;
      end
      ORIEX: begin
        w_alusrca     = 1'b1;
        w_alusrcb     = 2'b10;
        w_alu_op[1:0] = 2'b11;
        w_zeroext     = 1'b1;
        w_state_nxt   = IMMWB;
      end
      IMMWB: begin
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      BEQEX: begin
        w_alusrca     = 1'b1;
        w_alu_op[1:0] = 2'b01;
        w_pcsrc       = 2'b01;
        w_branch      = 1'b1;
        w_instr_done  = 1'b1;
      end
      BNEEX: begin
        w_alusrca     = 1'b1;
        w_alu_op[1:0] = 2'b01;
        w_pcsrc       = 2'b01;
        w_branch_ne   = 1'b1;
        w_instr_done  = 1'b1;
      end
      JEX: begin
        w_pcsrc      = 2'b10;
        w_pcwrite    = 1'b1;
        w_instr_done = 1'b1;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // Write enables are gated by reset so an aborted instruction cannot write anything.
  assign bus.pcwrite    = w_pcwrite   & reset_n;
  assign bus.branch     = w_branch    & reset_n;
  assign bus.branch_ne  = w_branch_ne & reset_n;
  assign bus.memwrite   = w_memwrite  & reset_n;
  assign bus.irwrite    = w_irwrite   & reset_n;
  assign bus.regwrite   = w_regwrite  & reset_n;
  assign bus.iord       = w_iord;
  assign bus.regdst     = w_regdst;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.zeroext    = w_zeroext;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.alu_op     = w_alu_op;
  assign bus.instr_done = w_instr_done;
  assign bus.illegal_op = w_illegal_op;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one instance with the ORI/BNE
// extension, one without, sharing clock, reset and inputs.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  mips_multicycle_ctrl_if #(.ALUOP_W(2)) bus_ext ();
  mips_multicycle_ctrl_if #(.ALUOP_W(2)) bus_base ();

  assign bus_ext.op         = op;
  assign bus_ext.mem_ready  = mem_ready;
  assign bus_base.op        = op;
  assign bus_base.mem_ready = mem_ready;

  mips_multicycle_ctrl #(.ALUOP_W(2), .EN_EXT(1), .MEM_WAIT(1)) u_dut_ext (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_ext.master)
  );

  mips_multicycle_ctrl #(.ALUOP_W(2), .EN_EXT(0), .MEM_WAIT(1)) u_dut_base (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_base.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to the next cycle; sampling point sits 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulse reset and leave the bench in the first FETCH cycle, mid-cycle.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  // Run one instruction from FETCH with mem_ready=1 and measure cycles to instr_done.
  task automatic run_lat(input string tag, input logic [5:0] opc, input int exp_len);
    int n;
    n = 0;
    do_reset();
    op = opc;
    mem_ready = 1'b1;
    #1;
    while (n < 20) begin
      n++;
      if (bus_ext.instr_done) break;
      tick();
    end
    check(tag, n, exp_len);
  endtask

  initial begin
    logic [3:0] lw_state [5];
    logic       lw_rw    [5];
    logic       lw_done  [5];
    int         n_mw;
    lw_state = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    lw_rw    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    lw_done  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held with memory ready: enables must stay low.
    op = 6'b100011;
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #12;
    check("rst_state",    bus_ext.state, 4'd0);
    check("rst_pcwrite",  bus_ext.pcwrite, 1'b0);
    check("rst_irwrite",  bus_ext.irwrite, 1'b0);
    check("rst_regwrite", bus_ext.regwrite, 1'b0);
    check("rst_memwrite", bus_ext.memwrite, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_pcwrite", bus_ext.pcwrite, 1'b1);
    check("rel_irwrite", bus_ext.irwrite, 1'b1);

    // lw walk: FETCH, DECODE, MEMADR, MEMRD, MEMWB.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lw_state%0d", i), bus_ext.state, lw_state[i]);
      check($sformatf("lw_regwrite%0d", i), bus_ext.regwrite, lw_rw[i]);
      check($sformatf("lw_memtoreg%0d", i), bus_ext.memtoreg, lw_rw[i]);
      check($sformatf("lw_done%0d", i), bus_ext.instr_done, lw_done[i]);
      tick();
    end
    check("lw_back_fetch", bus_ext.state, 4'd0);

    // sw with three wait cycles in MEMWR.
    do_reset();
    op = 6'b101011;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("sw_state_memwr", bus_ext.state, 4'd5);
    n_mw = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus_ext.memwrite) n_mw++;
      check($sformatf("sw_wait_done%0d", i), bus_ext.instr_done, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    if (bus_ext.memwrite) n_mw++;
    check("sw_memwrite_cycles", n_mw, 4);
    check("sw_ready_done", bus_ext.instr_done, 1'b1);
    check("sw_iord", bus_ext.iord, 1'b1);
    tick();
    check("sw_back_fetch", bus_ext.state, 4'd0);

    // FETCH waits on memory for two cycles.
    do_reset();
    op = 6'b000000;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("fw_state%0d", i), bus_ext.state, 4'd0);
      check($sformatf("fw_pcwrite%0d", i), bus_ext.pcwrite, 1'b0);
      check($sformatf("fw_irwrite%0d", i), bus_ext.irwrite, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("fw_pcwrite_rdy", bus_ext.pcwrite, 1'b1);
    check("fw_irwrite_rdy", bus_ext.irwrite, 1'b1);
    tick();
    check("fw_decode", bus_ext.state, 4'd1);

    // BNE: illegal without extension, BNEEX with it.
    do_reset();
    op = 6'b000101;
    tick();
    check("bne_base_illegal", bus_base.illegal_op, 1'b1);
    check("bne_base_done",    bus_base.instr_done, 1'b1);
    check("bne_ext_illegal",  bus_ext.illegal_op, 1'b0);
    check("bne_ext_alusrcb",  bus_ext.alusrcb, 2'b11);
    tick();
    check("bne_base_fetch",   bus_base.state, 4'd0);
    check("bne_base_ill_pulse", bus_base.illegal_op, 1'b0);
    check("bne_ext_state",    bus_ext.state, 4'd12);
    check("bne_ext_branch_ne", bus_ext.branch_ne, 1'b1);
    check("bne_ext_branch",   bus_ext.branch, 1'b0);
    check("bne_ext_alu_op",   bus_ext.alu_op, 2'b01);
    check("bne_ext_pcsrc",    bus_ext.pcsrc, 2'b01);
    check("bne_ext_done",     bus_ext.instr_done, 1'b1);

    // ORI on the extended instance.
    do_reset();
    op = 6'b001101;
    tick();
    check("ori_base_illegal", bus_base.illegal_op, 1'b1);
    tick();
    check("ori_state",   bus_ext.state, 4'd9);
    check("ori_alu_op",  bus_ext.alu_op, 2'b11);
    check("ori_zeroext", bus_ext.zeroext, 1'b1);
    check("ori_alusrcb", bus_ext.alusrcb, 2'b10);
    check("ori_alusrca", bus_ext.alusrca, 1'b1);
    tick();
    check("ori_wb_state",    bus_ext.state, 4'd10);
    check("ori_wb_regwrite", bus_ext.regwrite, 1'b1);
    check("ori_wb_regdst",   bus_ext.regdst, 1'b0);
    check("ori_wb_zeroext",  bus_ext.zeroext, 1'b0);

    // Unsupported opcode on the extended instance.
    do_reset();
    op = 6'b111111;
    tick();
    check("ill_ext_pulse", bus_ext.illegal_op, 1'b1);
    tick();
    check("ill_ext_fetch", bus_ext.state, 4'd0);

    // Latency table with zero wait states.
    run_lat("lat_lw",   6'b100011, 5);
    run_lat("lat_sw",   6'b101011, 4);
    run_lat("lat_rtype", 6'b000000, 4);
    check("rtype_wb_regdst", bus_ext.regdst, 1'b1);
    run_lat("lat_addi", 6'b001000, 4);
    run_lat("lat_ori",  6'b001101, 4);
    run_lat("lat_beq",  6'b000100, 3);
    check("beq_branch", bus_ext.branch, 1'b1);
    run_lat("lat_bne",  6'b000101, 3);
    run_lat("lat_j",    6'b000010, 3);
    check("j_pcsrc",   bus_ext.pcsrc, 2'b10);
    check("j_pcwrite", bus_ext.pcwrite, 1'b1);

    // Async reset in the middle of a stalled store.
    do_reset();
    op = 6'b101011;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("abort_pre_memwrite", bus_ext.memwrite, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_memwrite", bus_ext.memwrite, 1'b0);
    check("abort_state",    bus_ext.state, 4'd0);
    #3;
    reset_n = 1'b1;
    mem_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
